// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write arbiter: lane/burst defaults, counter
// width and the two-state FSM encoding.
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int BURST_MAX_DEF = 16;
  localparam int CNT_W_DEF     = $clog2(BURST_MAX_DEF) + 1;

  // FSM state enumeration, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Width needed to hold a lane index; never less than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req scanning upward
// (with wrap) from lastIdx+1; returns one-hot, index and a valid flag.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = NUM_REQ_DEF,
  localparam int IW = idxWidth(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] lastIdx,
  output logic [N-1:0]  oneHot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int            cand;
  logic [IW-1:0] candIdx;

  always_comb begin
    oneHot  = '0;
    idx     = '0;
    valid   = 1'b0;
    cand    = 0;
    candIdx = '0;
    // k runs 1..N so the previous owner is considered last.
    for (int k = 1; k <= N; k++) begin
      cand    = (int'(lastIdx) + k) % N;
      candIdx = IW'(cand);
      if (!valid && req[candIdx]) begin
        valid           = 1'b1;
        idx             = candIdx;
        oneHot[candIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port among NUM_REQ byte producers using round-robin
// bursts with a one-cycle bubble between owners.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [NUM_REQ-1:0]   req_in,
  input  logic [8*NUM_REQ-1:0] data_in,
  input  logic [3:0]           burstLen_in,
  output logic [NUM_REQ-1:0]   ack_out,
  output logic [7:0]           fifoData_out,
  output logic                 fifoWrite_out,
  input  logic                 fifoFull_in,
  output logic [NUM_REQ-1:0]   grant_out,
  output logic                 busy_out,
  output logic [0:0]           dbgState_out
);

  localparam int IW    = idxWidth(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX) + 1;

  // Handshake: a lane byte is consumed on a rising edge exactly when
  // ack_out[g] and fifoWrite_out are high in the preceding cycle; that
  // happens only in BURST while the owner requests and the FIFO is not full.

  logic [0:0]         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      grantIdx_q;
  logic [IW-1:0]      lastGrant_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0] pickOneHot;
  logic [IW-1:0]      pickIdx;
  logic               pickValid;
  logic [CNT_W-1:0]   lenEff;
  logic               ownerReq;
  logic               xfer;
  logic [7:0]         laneByte;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req_in),
    .lastIdx (lastGrant_q),
    .oneHot  (pickOneHot),
    .idx     (pickIdx),
    .valid   (pickValid)
  );

  // Zero selects the maximum; anything above the maximum is clamped to it.
  always_comb begin
    lenEff = CNT_W'(BURST_MAX);
    if (burstLen_in != 4'd0 && int'(burstLen_in) <= BURST_MAX) begin
      lenEff = CNT_W'(burstLen_in);
    end
  end

  always_comb begin
    laneByte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        laneByte = data_in[8*i +: 8];
      end
    end
  end

  assign ownerReq = |(req_in & grant_q);
  assign xfer     = (state_q == ST_BURST) && ownerReq && !fifoFull_in;

  assign fifoWrite_out = xfer;
  assign ack_out       = xfer ? grant_q : '0;
  assign fifoData_out  = (state_q == ST_BURST) ? laneByte : 8'h00;
  assign grant_out     = grant_q;
  assign busy_out      = (state_q == ST_BURST);
  assign dbgState_out  = state_q;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grantIdx_q  <= '0;
      lastGrant_q <= IW'(NUM_REQ - 1);
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pickValid) begin
            state_q    <= ST_BURST;
            grant_q    <= pickOneHot;
            grantIdx_q <= pickIdx;
            cnt_q      <= lenEff;
          end
        end
        ST_BURST: begin
          if (xfer) begin
            if (cnt_q == CNT_W'(1)) begin
              state_q     <= ST_IDLE;
              grant_q     <= '0;
              lastGrant_q <= grantIdx_q;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end else if (!ownerReq) begin
            // Owner went quiet: give the port up without writing.
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            lastGrant_q <= grantIdx_q;
            cnt_q       <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  a_no_write_when_full : assert property (
    @(posedge clk_in) disable iff (!reset_in) !(fifoWrite_out && fifoFull_in));
  a_ack_onehot0 : assert property (
    @(posedge clk_in) disable iff (!reset_in) $onehot0(ack_out));
  a_grant_in_burst : assert property (
    @(posedge clk_in) disable iff (!reset_in) busy_out == $onehot(grant_out));

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomised and directed bench for fifo_write_arbiter with a lane-level
// reference model feeding per-cycle and per-write expectation queues.
module tb_fifo_write_arbiter;

  localparam int N    = 4;
  localparam int BMAX = 16;
  localparam int W    = N + 8;

  logic           clk_in;
  logic           reset_in;
  logic [N-1:0]   req_in;
  logic [8*N-1:0] data_in;
  logic [3:0]     burstLen_in;
  logic           fifoFull_in;
  logic [N-1:0]   ack_out;
  logic [7:0]     fifoData_out;
  logic           fifoWrite_out;
  logic [N-1:0]   grant_out;
  logic           busy_out;
  logic [0:0]     dbgState_out;

  fifo_write_arbiter #(.NUM_REQ(N), .BURST_MAX(BMAX)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .req_in        (req_in),
    .data_in       (data_in),
    .burstLen_in   (burstLen_in),
    .ack_out       (ack_out),
    .fifoData_out  (fifoData_out),
    .fifoWrite_out (fifoWrite_out),
    .fifoFull_in   (fifoFull_in),
    .grant_out     (grant_out),
    .busy_out      (busy_out),
    .dbgState_out  (dbgState_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic         busy;
    logic [N-1:0] grant;
    logic         wr;
    logic [N-1:0] ack;
    logic [7:0]   data;
  } cyc_t;

  cyc_t         cyc_q[$];
  logic [W-1:0] exp_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  // Reference model: who owns the port, how many bytes are left, who owned last.
  int m_owner = -1;
  int m_remain = 0;
  int m_last = N - 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [N-1:0] req, input logic [3:0] len,
                       input logic full, input logic rst);
    cyc_t e;
    int   c;
    @(posedge clk_in);
    #1;
    reset_in    = rst;
    req_in      = req;
    burstLen_in = len;
    fifoFull_in = full;
    data_in     = $urandom;
    e = '0;
    if (!rst) begin
      m_owner  = -1;
      m_remain = 0;
      m_last   = N - 1;
    end else if (m_owner >= 0) begin
      e.busy           = 1'b1;
      e.grant[m_owner] = 1'b1;
      e.data           = data_in[8*m_owner +: 8];
      if (req[m_owner] && !full) begin
        e.wr  = 1'b1;
        e.ack = e.grant;
        exp_q.push_back({e.ack, e.data});
        m_remain--;
        if (m_remain == 0) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else if (!req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (req != '0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (m_owner < 0 && req[c]) m_owner = c;
      end
      m_remain = (len == 4'd0) ? BMAX : int'(len);
    end
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 4'd0, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  cyc_t         mon_e;
  logic [W-1:0] mon_w;

  always @(negedge clk_in) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      check("busy",  32'(busy_out),      32'(mon_e.busy));
      check("grant", 32'(grant_out),     32'(mon_e.grant));
      check("write", 32'(fifoWrite_out), 32'(mon_e.wr));
      check("ack",   32'(ack_out),       32'(mon_e.ack));
      check("data",  32'(fifoData_out),  32'(mon_e.data));
      if (fifoWrite_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(1), 32'(0));
        end else begin
          mon_w = exp_q.pop_front();
          check("write_stream", 32'({ack_out, fifoData_out}), 32'(mon_w));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_in    = 1'b0;
    req_in      = '0;
    data_in     = '0;
    burstLen_in = 4'd0;
    fifoFull_in = 1'b0;

    repeat (3) drive('0, 4'd0, 1'b0, 1'b0);
    // single lane, burst of four
    repeat (7) drive(4'b0001, 4'd4, 1'b0, 1'b1);
    idle(3);

    // all lanes, burst of two, starting from a fresh reset
    repeat (2) drive('0, 4'd0, 1'b0, 1'b0);
    repeat (16) drive(4'b1111, 4'd2, 1'b0, 1'b1);
    idle(3);

    // stall on full mid-burst
    drive(4'b0010, 4'd4, 1'b0, 1'b1);
    drive(4'b0010, 4'd4, 1'b0, 1'b1);
    repeat (3) drive(4'b0010, 4'd4, 1'b1, 1'b1);
    repeat (4) drive(4'b0010, 4'd4, 1'b0, 1'b1);
    idle(3);

    // owner drops request early; lane 3 must beat lane 0 next
    drive(4'b0100, 4'd8, 1'b0, 1'b1);
    repeat (3) drive(4'b1101, 4'd8, 1'b0, 1'b1);
    repeat (5) drive(4'b1001, 4'd8, 1'b0, 1'b1);
    idle(3);

    // reset mid-burst, then round-robin restarts at lane 0
    repeat (6) drive(4'b0001, 4'd0, 1'b0, 1'b1);
    repeat (2) drive(4'b0001, 4'd0, 1'b0, 1'b0);
    repeat (5) drive(4'b1010, 4'd0, 1'b0, 1'b1);
    idle(3);

    // full-length burst with burstLen changing underneath it
    drive(4'b0001, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(4'b0001, 4'($urandom_range(1, 15)), 1'b0, 1'b1);
    idle(3);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(N'($urandom), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) != 0));
    end
    idle(4);

    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    check("cyc_q_drained", 32'(cyc_q.size()), 32'(0));
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of producer lanes sharing one FIFO write port.
REQ-002 Parameter BURST_MAX, default 16: maximum bytes per grant; burstLen_in value 0 selects this.
REQ-003 clk_in  input  1  sole clock; all state on rising edge.
REQ-004 reset_in  input  1  asynchronous, active-low reset.
REQ-005 req_in  input  NUM_REQ  per lane, high = byte valid on that lane.
REQ-006 data_in  input  8*NUM_REQ  packed lane bytes; lane i at bits [8i+7:8i].
REQ-007 burstLen_in  input  4  burst length 1-15, 0 = BURST_MAX; sampled at grant.
REQ-008 ack_out  input-facing output  NUM_REQ  one-hot; lane byte consumed this edge.
REQ-009 fifoData_out  output  8  byte to FIFO din.
REQ-010 fifoWrite_out  output  1  FIFO wr_en.
REQ-011 fifoFull_in  input  1  FIFO full flag.
REQ-012 grant_out  output  NUM_REQ  registered one-hot current owner; all-zero in IDLE.
REQ-013 busy_out  output  1  high in state BURST.

Function
REQ-014 Two states SHALL exist: IDLE, BURST.
REQ-015 IDLE: if any req_in bit high, the arbiter SHALL select the first requesting lane scanning upward (with wrap) from lastGrant+1, load grant, load burst counter with effective length, and enter BURST next edge.
REQ-016 IDLE with no request: SHALL remain IDLE; outputs zero.
REQ-017 Transfer condition: state BURST AND req_in[g] AND NOT fifoFull_in, where g is the granted lane.
REQ-018 On transfer, fifoWrite_out=1, ack_out[g]=1, fifoData_out=lane g byte, all combinational in the same cycle; otherwise fifoWrite_out=0, ack_out=0.
REQ-019 fifoData_out SHALL be lane g byte while in BURST, 0x00 in IDLE.
REQ-020 Burst counter SHALL decrement only on transfer; fifoFull_in high stalls without decrement, grant held.
REQ-021 BURST -> IDLE when a transfer occurs with counter==1, or when req_in[g]=0 (no transfer that cycle); lastGrant<=g on exit.
REQ-022 Exactly one bubble cycle (IDLE) SHALL separate consecutive bursts.
REQ-023 Requests on non-granted lanes during BURST SHALL be ignored, never acked.
REQ-024 burstLen_in changes during BURST SHALL not affect the current burst.
REQ-025 Counter width SHALL be clog2(BURST_MAX)+1; no wrap below 1.
REQ-026 At most one ack_out bit and fifoWrite_out SHALL never assert when fifoFull_in=1.

Reset
REQ-027 reset_in low SHALL immediately force IDLE, grant_out=0, busy_out=0, counter=0, ack_out=0, fifoWrite_out=0, fifoData_out=0x00.
REQ-028 lastGrant SHALL reset to NUM_REQ-1 so lane 0 wins first arbitration.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no further write; after release the first grant follows REQ-028.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enumeration, NUM_REQ and BURST_MAX defaults, and the counter width constant.
REQ-031 One sub-module rr_pick (combinational round-robin priority selector: req vector, last index -> one-hot + index, valid) SHALL be used.
REQ-032 FSM, counter, grant and lastGrant registers SHALL reside in fifo_write_arbiter.

Verification
REQ-033 Reset release, req_in=0001, burstLen 4, full=0 -> grant 0001 one cycle later, 4 writes of lane 0 bytes on consecutive cycles, IDLE one cycle.
REQ-034 req_in=1111 continuous, burstLen 2 -> grant order 0,1,2,3,0; 2 writes each; one bubble between bursts.
REQ-035 Lane 1 bursting, fifoFull_in high 3 cycles after write 1 of 4 -> no write/ack for 3 cycles, grant held, remaining 3 writes after full drops.
REQ-036 Lane 2 granted burstLen 8, req_in[2] drops after 3 writes -> IDLE next edge; lastGrant=2, next pending lane 3 wins before lane 0.
REQ-037 reset_in low mid-burst after 5 of 16 writes -> outputs zero same cycle; after release req_in=1010 -> lane 1 granted first.
REQ-038 burstLen_in=0 -> 16 writes per grant; burstLen_in changed mid-burst -> current count unaffected.
